// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, FSM state and op encodings for dmem_block_ram
package dmem_pkg;

  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_t;

  // Counter only has to hold LATENCY-2.
  function automatic int cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency - 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port 128-bit block storage with one write port and a registered read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic               rd_clear,
  input  logic [IDX_W-1:0]   idx,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  // Zero contents at time 0; the array itself is never reset.
  logic [BLOCK_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_clear) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_block_ram.sv
// rtl/dmem_block_ram.sv - fixed-latency block data memory behind the data cache; optional DMEM_RANGE_CHECK_EN
module dmem_block_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic                    clock,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0] MEM_BLOCK_ADDR,
  input  logic [BLOCK_W-1:0]      MEM_WRITE_DATA,
  output logic [BLOCK_W-1:0]      MEM_READ_DATA,
  output logic                    MEM_BUSYWAIT,
  output logic                    ADDR_ERROR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);

  dmem_state_t             state;
  dmem_state_t             state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic [BLOCK_W-1:0]      wdata_q;
  dmem_op_t                op_q;

  logic request;
  logic commit;
  logic illegal;
  logic wr_en;
  logic rd_en;
  logic rd_clear;

  assign request = MEM_READ | MEM_WRITE;
  assign commit  = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clock) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (request) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MEM_BUSYWAIT = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state)
      IDLE: MEM_BUSYWAIT = request;
      BUSY: begin
        MEM_BUSYWAIT = 1'b1;
        wr_en        = commit && (op_q == OP_WRITE) && !illegal && !RESET;
        rd_en        = commit && (op_q == OP_READ);
      end
      default: MEM_BUSYWAIT = 1'b0;
    endcase
  end

  // Illegal reads return zeros, which shares the reset clear path.
  assign rd_clear = RESET | (rd_en & illegal);

  // Request is captured once; anything the cache does during BUSY is ignored.
  always_ff @(posedge clock) begin
    if (RESET) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            addr_q  <= MEM_BLOCK_ADDR;
            wdata_q <= MEM_WRITE_DATA;
            op_q    <= MEM_WRITE ? OP_WRITE : OP_READ;
            cnt     <= CNT_W'(LATENCY - 2);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  assign illegal = (addr_q[BLOCK_ADDR_W-1:IDX_W] != '0);

  always_ff @(posedge clock) begin
    if (RESET) begin
      ADDR_ERROR <= 1'b0;
    end else begin
      ADDR_ERROR <= commit & illegal;
    end
  end
`else
  // Upper address bits alias modulo DEPTH.
  logic unused_upper_addr;
  assign unused_upper_addr = ^addr_q[BLOCK_ADDR_W-1:IDX_W];
  assign illegal           = 1'b0;
  assign ADDR_ERROR        = 1'b0;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock    (clock),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_clear (rd_clear),
    .idx      (addr_q[IDX_W-1:0]),
    .wdata    (wdata_q),
    .rdata    (MEM_READ_DATA)
  );

endmodule

// File: doc/dmem_block_ram.md
# dmem_block_ram

Block-granular data memory that sits directly downstream of the data cache and serves its 128-bit line fills and write-backs. Each access has a fixed, parameterised latency. It stalls the cache through a `MEM_BUSYWAIT`-style handshake. Storage is an array of 128-bit blocks, each addressed by a 28-bit block address (byte address bits [31:4]).

## Interface
Parameters:
- `DEPTH`, 256, number of 128-bit blocks (power of two, ≥2); 4 KiB by default.
- `LATENCY`, 5, cycles `BUSYWAIT` stays high per access (≥2).

Ports:
- `clock`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `MEM_READ`  in  1  block read request from the cache.
- `MEM_WRITE`  in  1  block write request from the cache.
- `MEM_BLOCK_ADDR`  in  28  block address.
- `MEM_WRITE_DATA`  in  128  block to store; word 0 in bits [31:0].
- `MEM_READ_DATA`  out  128  fetched block (registered).
- `MEM_BUSYWAIT`  out  1  high while an access is in progress.
- `ADDR_ERROR`  out  1  out-of-range flag; tied 0 unless `DMEM_RANGE_CHECK_EN` is defined.

## Operation
- FSM states: `IDLE`, `BUSY`, `RELEASE`. Reset values: state `IDLE`, `MEM_READ_DATA` 0, `ADDR_ERROR` 0, counter 0.
- `MEM_BUSYWAIT` is combinational:
  - It is 1 in `IDLE` when `MEM_READ | MEM_WRITE`.
  - It is 1 throughout `BUSY`.
  - It is 0 otherwise, including `RELEASE`.
- **`IDLE`, request present at an edge:**
  - Latch the address, the write data and the op.
  - If both requests are high, write wins.
  - Load the counter with `LATENCY-2` and go to `BUSY`.
- **`BUSY`:**
  - While the counter is ≠0, decrement it at each edge.
  - At the edge where the counter is 0, perform the access and go to `RELEASE`.
  - Write: `array[idx] <= latched data`.
  - Read: `MEM_READ_DATA <= array[idx]`.
- **`RELEASE`:** lasts exactly one cycle, then returns unconditionally to `IDLE`. A request still held during this cycle is ignored.
- **Index:** `idx = MEM_BLOCK_ADDR[$clog2(DEPTH)-1:0]`. Upper address bits are ignored unless range checking is enabled.
- **Input changes in `BUSY`:** changes to the address, data or requests are ignored. A request dropped mid-access does not abort it; the access still completes.
- **Read data hold:** `MEM_READ_DATA` holds its value until the next read completes. Writes never change it.
- **Reset mid-access:** return to `IDLE` next edge; any pending write is discarded and `MEM_READ_DATA` is cleared to 0. Array contents are not affected by `RESET`.
- **Power-up:** the array is zero-initialised at time 0 (simulation only).

## Timing
- The request is sampled at edge E0. `MEM_BUSYWAIT` is high from the cycle the request appears through the cycle before edge E0+`LATENCY`-1: exactly `LATENCY` cycles.
- The access commits at edge E0+`LATENCY`-1. `MEM_READ_DATA` is valid in the following `RELEASE` cycle and thereafter.
- The requester must deassert or change its request during `RELEASE`. A new request is accepted at the first `IDLE` edge, so a write-back followed by a fill runs back to back with one idle-low cycle between them.
- Throughput: one access per `LATENCY`+1 cycles.

## Configuration
Macro: `DMEM_RANGE_CHECK_EN`.
- **Defined:** any nonzero `MEM_BLOCK_ADDR` bit above the index width marks the access illegal.
  - An illegal write is suppressed.
  - An illegal read loads 128'd0.
  - `ADDR_ERROR` is high for the `RELEASE` cycle only.
  - Latency is unchanged.
- **Undefined:** upper bits are ignored, so the address aliases modulo `DEPTH`. `ADDR_ERROR` is constant 0.

## Structure
- **Package `dmem_pkg`:**
  - `BLOCK_W`=128, `BLOCK_ADDR_W`=28.
  - State enum `dmem_state_t` (`IDLE`/`BUSY`/`RELEASE`).
- **Sub-module `dmem_array`:** the synchronous single-port storage, with one write port and one registered read port. The FSM, counter and range check stay in the top level.

## Test plan
- **Reset then read:** `RESET` then read of block 0x3 → `MEM_BUSYWAIT` high 5 cycles, then `MEM_READ_DATA`=0 in `RELEASE`.
- **Write then read back:** write 0x0123…CDEF to block 0x12, then read 0x12 → the same 128-bit value. Each access shows 5 busy cycles and one `RELEASE` cycle with busywait low.
- **Write-back then fill:** write block 0x7, then an immediate read of 0x27 with `DEPTH`=256 → two accesses separated by exactly one low cycle. The data for 0x27 is independent of the 0x7 write.
- **Inputs changed mid-access:** a read of 0x5 that is dropped, with the address switched to 0x6 during `BUSY` → returns the block-0x5 data and no second access starts.
- **Reset mid-access:** `RESET` in the third `BUSY` cycle of a write to 0x9 → `IDLE` next edge, `MEM_READ_DATA`=0, and a later read of 0x9 returns the old value.
- **Range check:** with `DMEM_RANGE_CHECK_EN`, a write to 0x100 → `ADDR_ERROR` is 1 for one cycle and block 0x0 is unchanged. Without the macro, the same write lands in block 0x0.
